// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//
// Multiplies use radix-2 shift-add and divides use restoring shift-subtract.
// Both work on operand magnitudes, one bit per cycle for WIDTH cycles.
// The sign is applied to the finished product, quotient or remainder.
// Divide-by-zero and signed overflow resolve in IDLE and skip the iterations.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   Defined   : multiply ops use a single-cycle combinational multiplier
//               and complete one cycle after the start.
//   Undefined : every op uses the iterative datapath, and no hardware
//               multiplier is inferred.
//
// Ports:
//   Clk_i     core clock; all state changes on posedge
//   Rst_n_i   synchronous active-low reset
//   Start_i   start request, taken only while Busy_o is low
//   Op_i      RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   A_i, B_i  rs1 / rs2 operands
//   Rd_i      destination register index
//   Flush_i   abort the in-flight operation
//   Busy_o    operation in progress; the core stalls on it
//   Done_o    one-cycle write-enable pulse for the register file
//   Rd_o      latched destination index
//   Result_o  result; valid while Done_o is high, held until the next Done_o
module muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      Clk_i,
  input  logic                      Rst_n_i,
  input  logic                      Start_i,
  input  logic [2:0]                Op_i,
  input  logic [WIDTH-1:0]          A_i,
  input  logic [WIDTH-1:0]          B_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_i,
  input  logic                      Flush_i,
  output logic                      Busy_o,
  output logic                      Done_o,
  output logic [REG_ADDR_WIDTH-1:0] Rd_o,
  output logic [WIDTH-1:0]          Result_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state, state_next;
  logic [2:0]                op_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [WIDTH-1:0]          opb_q;
  logic [2*WIDTH-1:0]        acc_q;
  logic                      neg_res_q;
  logic                      neg_rem_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [WIDTH-1:0]          result_q;

  logic                      a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]          a_mag, b_mag;
  logic                      div_zero, div_ovf, special, accept;
  logic                      fast_sel;
  logic [2*WIDTH-1:0]        fast_prod;
  logic [WIDTH:0]            mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]        mul_next, div_next;
  logic [2*WIDTH-1:0]        prod_signed;
  logic [WIDTH-1:0]          quo_signed, rem_signed, final_res;

  // Operand decode for a new request: signedness, magnitudes, special cases
  always_comb begin
    a_signed = (Op_i == 3'b001) || (Op_i == 3'b010) || (Op_i == 3'b100) || (Op_i == 3'b110);
    b_signed = (Op_i == 3'b001) || (Op_i == 3'b100) || (Op_i == 3'b110);
    a_neg    = a_signed & A_i[WIDTH-1];
    b_neg    = b_signed & B_i[WIDTH-1];
    a_mag    = a_neg ? -A_i : A_i;
    b_mag    = b_neg ? -B_i : B_i;
    div_zero = Op_i[2] && (B_i == '0);
    div_ovf  = Op_i[2] && !Op_i[0] && (A_i == {1'b1, {(WIDTH-1){1'b0}}}) && (B_i == '1);
    special  = div_zero || div_ovf;
    accept   = Start_i && !Flush_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extended operands make the low 2*WIDTH product bits correct for every multiply op
  logic [2*WIDTH-1:0] fast_a, fast_b;
  always_comb begin
    fast_a    = {{WIDTH{a_neg}}, A_i};
    fast_b    = {{WIDTH{b_neg}}, B_i};
    fast_prod = fast_a * fast_b;
    fast_sel  = !Op_i[2];
  end
`else
  always_comb begin
    fast_prod = '0;
    fast_sel  = 1'b0;
  end
`endif

  // One iteration step. acc_q holds {partial product, multiplier} when multiplying.
  // It holds {remainder, dividend/quotient} when dividing.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_next  = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
  end

  // Sign correction and result selection from the finished accumulator
  always_comb begin
    prod_signed = neg_res_q ? -acc_q : acc_q;
    quo_signed  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_signed  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    final_res   = '0;
    if (op_q[2])
      final_res = op_q[1] ? rem_signed : quo_signed;
    else if (op_q[1:0] == 2'b00)
      final_res = prod_signed[WIDTH-1:0];
    else
      final_res = prod_signed[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge Clk_i) begin
    if (!Rst_n_i)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (special || fast_sel) ? DONE : CALC;
      CALC: begin
        if (Flush_i)
          state_next = IDLE;
        else if (cnt_q == LAST_CNT)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Special cases preload the accumulator so that the uncorrected
  // quotient/remainder halves already hold the architectural result.
  always_ff @(posedge Clk_i) begin
    if (!Rst_n_i) begin
      op_q      <= '0;
      rd_q      <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= Op_i;
            rd_q      <= Rd_i;
            opb_q     <= b_mag;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            if (fast_sel)
              acc_q <= fast_prod;
            else if (div_zero)
              acc_q <= {A_i, {WIDTH{1'b1}}};
            else if (div_ovf)
              acc_q <= {{WIDTH{1'b0}}, A_i};
            else begin
              acc_q     <= {{WIDTH{1'b0}}, a_mag};
              neg_res_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
            end
          end
        end
        CALC: begin
          acc_q <= op_q[2] ? div_next : mul_next;
          cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
        DONE:    result_q <= final_res;
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    Busy_o   = (state != IDLE);
    Done_o   = (state == DONE);
    Rd_o     = rd_q;
    Result_o = (state == DONE) ? final_res : result_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH=32).
// It drives directed and random RV32M operations and compares each result and
// completion latency against a plain-arithmetic reference model.
// It also exercises flush, reset during an operation, and a start that
// arrives while the unit is busy.
module tb_muldiv_unit;

  logic        Clk_i;
  logic        Rst_n_i;
  logic        Start_i;
  logic [2:0]  Op_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic [4:0]  Rd_i;
  logic        Flush_i;
  logic        Busy_o;
  logic        Done_o;
  logic [4:0]  Rd_o;
  logic [31:0] Result_o;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] lastResult = '0;

  muldiv_unit #(.WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .Clk_i    (Clk_i),
    .Rst_n_i  (Rst_n_i),
    .Start_i  (Start_i),
    .Op_i     (Op_i),
    .A_i      (A_i),
    .B_i      (B_i),
    .Rd_i     (Rd_i),
    .Flush_i  (Flush_i),
    .Busy_o   (Busy_o),
    .Done_o   (Done_o),
    .Rd_o     (Rd_o),
    .Result_o (Result_o)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  // Last-resort guard in case something hangs outside the bounded loops
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Reference model: RV32M semantics with 64-bit integer arithmetic
  function automatic logic [31:0] modelResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub, q;
    logic [63:0] prod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      3'd0: begin prod = 64'(ua * ub); return prod[31:0];  end
      3'd1: begin prod = 64'(sa * sb); return prod[63:32]; end
      3'd2: begin prod = 64'(sa * ub); return prod[63:32]; end
      3'd3: begin prod = 64'(ua * ub); return prod[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return 32'(q);
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        q = ua / ub; return 32'(q);
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return 32'(q);
      end
      default: begin
        if (b == 32'h0) return a;
        q = ua % ub; return 32'(q);
      end
    endcase
  endfunction

  // Cycles from the accepting edge until the Done_o cycle
  function automatic int modelLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 32'h0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Issue one operation from an idle negedge and follow it to completion.
  // A nonzero intruderCycle pulses an extra Start_i in that busy cycle.
  // flushAtDone asserts Flush_i during the Done_o cycle.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int intruderCycle, input logic flushAtDone);
    int          cyc;
    int          busyDrops;
    int          expLat;
    logic [31:0] expRes;
    expRes = modelResult(op, a, b);
    expLat = modelLatency(op, a, b);
    checkOutput("idle_before_start", 32'(Busy_o), 32'd0);
    Start_i = 1'b1; Op_i = op; A_i = a; B_i = b; Rd_i = rd;
    @(posedge Clk_i);
    @(negedge Clk_i);
    Start_i = 1'b0; Op_i = 3'($urandom); A_i = $urandom; B_i = $urandom; Rd_i = 5'($urandom);
    cyc = 1;
    busyDrops = 0;
    while (cyc < 100) begin
      Start_i = (cyc == intruderCycle);
      if (Done_o) break;
      if (!Busy_o) busyDrops++;
      @(negedge Clk_i);
      cyc++;
    end
    Start_i = 1'b0;
    checkOutput("latency", 32'(cyc), 32'(expLat));
    checkOutput("busy_held", 32'(busyDrops), 32'd0);
    checkOutput("busy_at_done", 32'(Busy_o), 32'd1);
    checkOutput("result", Result_o, expRes);
    checkOutput("rd", 32'(Rd_o), 32'(rd));
    Flush_i = flushAtDone;
    @(negedge Clk_i);
    Flush_i = 1'b0;
    checkOutput("done_one_cycle", 32'(Done_o), 32'd0);
    checkOutput("busy_released", 32'(Busy_o), 32'd0);
    checkOutput("result_hold", Result_o, expRes);
    lastResult = expRes;
  endtask

  initial begin
    int          doneSeen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          sel;

    Rst_n_i = 1'b0; Start_i = 1'b0; Flush_i = 1'b0;
    Op_i = '0; A_i = '0; B_i = '0; Rd_i = '0;
    repeat (2) @(posedge Clk_i);
    @(negedge Clk_i);
    checkOutput("reset_busy", 32'(Busy_o), 32'd0);
    checkOutput("reset_done", 32'(Done_o), 32'd0);
    checkOutput("reset_rd", 32'(Rd_o), 32'd0);
    checkOutput("reset_result", Result_o, 32'd0);
    Rst_n_i = 1'b1;
    @(negedge Clk_i);

    // Directed vectors, issued back to back
    applyStimulus(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  0, 1'b0);
    applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  0, 1'b0);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  0, 1'b0);
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  0, 1'b0);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  0, 1'b0);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  0, 1'b0);
    applyStimulus(3'd5, 32'd100,        32'd7,         5'd7,  0, 1'b0);
    applyStimulus(3'd7, 32'd100,        32'd7,         5'd8,  0, 1'b0);
    applyStimulus(3'd5, 32'd5,          32'd0,         5'd9,  0, 1'b0);
    applyStimulus(3'd6, 32'd5,          32'd0,         5'd10, 0, 1'b0);
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 1'b0);
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  0, 1'b0);

    // Flush in CALC: assert during cycle T+10, idle at T+11, restart completes at T+44
    Start_i = 1'b1; Op_i = 3'd5; A_i = 32'd1000; B_i = 32'd3; Rd_i = 5'd12;
    @(posedge Clk_i);
    @(negedge Clk_i);
    Start_i = 1'b0;
    doneSeen = 0;
    repeat (9) begin
      if (Done_o) doneSeen++;
      @(negedge Clk_i);
    end
    Flush_i = 1'b1;
    @(negedge Clk_i);
    Flush_i = 1'b0;
    checkOutput("flush_busy", 32'(Busy_o), 32'd0);
    checkOutput("flush_no_done", 32'(doneSeen + int'(Done_o)), 32'd0);
    checkOutput("flush_result_kept", Result_o, lastResult);
    applyStimulus(3'd7, 32'd12345, 32'd100, 5'd13, 0, 1'b0);

    // Start with Flush in IDLE is dropped
    Start_i = 1'b1; Flush_i = 1'b1; Op_i = 3'd5; A_i = 32'd9; B_i = 32'd2; Rd_i = 5'd14;
    @(negedge Clk_i);
    Start_i = 1'b0; Flush_i = 1'b0;
    doneSeen = 0;
    repeat (3) begin
      if (Busy_o || Done_o) doneSeen++;
      @(negedge Clk_i);
    end
    checkOutput("idle_flush_start_dropped", 32'(doneSeen), 32'd0);

    // Flush during the DONE cycle keeps that pulse
    applyStimulus(3'd4, 32'hFFFF_FF00, 32'd16, 5'd15, 0, 1'b1);

    // Start while busy is ignored
    applyStimulus(3'd0, 32'd123456, 32'd789, 5'd9, 20, 1'b0);
    applyStimulus(3'd5, 32'd77777, 32'd13, 5'd17, 5, 1'b0);

    // Reset during an operation abandons it
    Start_i = 1'b1; Op_i = 3'd0; A_i = 32'd7; B_i = 32'd3; Rd_i = 5'd20;
    @(posedge Clk_i);
    @(negedge Clk_i);
    Start_i = 1'b0;
    repeat (4) @(negedge Clk_i);
    Rst_n_i = 1'b0;
    @(negedge Clk_i);
    Rst_n_i = 1'b1;
    checkOutput("midreset_busy", 32'(Busy_o), 32'd0);
    checkOutput("midreset_done", 32'(Done_o), 32'd0);
    checkOutput("midreset_rd", 32'(Rd_o), 32'd0);
    checkOutput("midreset_result", Result_o, 32'd0);
    doneSeen = 0;
    repeat (40) begin
      if (Done_o) doneSeen++;
      @(negedge Clk_i);
    end
    checkOutput("midreset_no_done", 32'(doneSeen), 32'd0);
    lastResult = '0;

    // Random operations with a bias toward the special operand pairs
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) rb = -32'($urandom_range(1, 15));
      applyStimulus(rop, ra, rb, 5'($urandom), 0, 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
